// File: rtl/data_memory_access.sv
// data_memory_access
//   Data-side load/store unit with its own word-wide synchronous memory.
//   It accepts one load or store at a time. Byte and halfword stores are
//   done as a read-modify-write over two cycles. Loads return data that is
//   sign- or zero-extended from the addressed little-endian lane.
//
// Ports
//   clk          clock; all state updates on the rising edge
//   nrst         asynchronous active-low reset
//   req          request strobe, sampled only while idle
//   we           1 = store, 0 = load
//   size         00 byte, 01 halfword, 10 word, 11 illegal
//   unsigned_ld  1 = zero-extend a sub-word load, 0 = sign-extend
//   addr         byte address
//   w_data       store data; the low byte/halfword is used for sub-word stores
//   r_data       registered load result (stores leave it untouched)
//   busy         high whenever the unit is not idle
//   done         one-cycle completion pulse
//   err          one-cycle error pulse, coincident with done
module data_memory_access #(
  parameter int DEPTH_WORDS = 24576
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] w_data,
  output logic [31:0] r_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [31:0]      merge_buf;
  logic             err_q;
  logic             we_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [IDX_W+1:0] addr_q;
  logic [31:0]      wdata_q;

  logic             illegal;
  logic [IDX_W-1:0] idx;
  logic [31:0]      mem_rd;
  logic             mem_we;
  logic [31:0]      mem_wdata;

  // Pick the addressed lane out of a memory word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  off,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = 16'(word >> {off[1], 4'b0000});
    case (sz)
      2'b00:   load_extend = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   load_extend = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

  // Replace the addressed byte/halfword lane of a word with new store data.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [1:0]  sz,
                                             input logic [1:0]  off,
                                             input logic [31:0] wd);
    logic [31:0] mask;
    logic [31:0] ins;
    if (sz == 2'b00) begin
      mask = 32'h0000_00FF << {off, 3'b000};
      ins  = {24'h0, wd[7:0]} << {off, 3'b000};
    end else begin
      mask = 32'h0000_FFFF << {off[1], 4'b0000};
      ins  = {16'h0, wd[15:0]} << {off[1], 4'b0000};
    end
    merge_lane = (word & ~mask) | (ins & mask);
  endfunction

  // Alignment and range are judged on the live request so an illegal access
  // never reaches the memory.
  always_comb begin
    illegal = 1'b0;
    if (size == 2'b11)                     illegal = 1'b1;
    if (size == 2'b01 && addr[0])          illegal = 1'b1;
    if (size == 2'b10 && addr[1:0] != 2'b00) illegal = 1'b1;
    if (addr[31:2] >= DEPTH_LIM)           illegal = 1'b1;
  end

  assign idx    = addr_q[IDX_W+1:2];
  assign mem_rd = mem[idx];
  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);
  assign err    = done & err_q;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req) state_nxt = illegal ? ST_DONE : ST_ACCESS;
      ST_ACCESS: state_nxt = (we_q && size_q != 2'b10) ? ST_MERGE : ST_DONE;
      ST_MERGE:  state_nxt = ST_DONE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= ST_IDLE;
      err_q     <= 1'b0;
      r_data    <= 32'h0;
      merge_buf <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && req)
        err_q <= illegal;
      if (state == ST_ACCESS && !we_q)
        r_data <= load_extend(mem_rd, size_q, addr_q[1:0], uns_q);
      if (state == ST_ACCESS && we_q && size_q != 2'b10)
        merge_buf <= mem_rd;
    end
  end

  // Request copies are plain data: they are only consumed after an accept.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && req) begin
      we_q    <= we;
      size_q  <= size;
      uns_q   <= unsigned_ld;
      addr_q  <= addr[IDX_W+1:0];
      wdata_q <= w_data;
    end
  end

  // Word stores write on the ACCESS edge; sub-word stores on the MERGE edge.
  // Reset drops the state to idle, so an aborted merge never writes.
  assign mem_we    = (state == ST_ACCESS && we_q && size_q == 2'b10) ||
                     (state == ST_MERGE);
  assign mem_wdata = (state == ST_MERGE) ?
                     merge_lane(merge_buf, size_q, addr_q[1:0], wdata_q) :
                     wdata_q;

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[idx] <= mem_wdata;
  end

endmodule
